// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between fetch, execute and the branch resolve queue.
// master drives predictions/resolutions; slave is the queue itself.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [31:0]   push_pc;
  logic          push_taken;
  logic [31:0]   push_target;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          resolve_valid;
  logic          resolve_taken;
  logic [31:0]   resolve_target;
  logic          flush;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   branch_count;
  logic [31:0]   mispredict_count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, push_pc, push_taken, push_target,
    output resolve_valid, resolve_taken, resolve_target,
    output flush,
    input  full, empty, count,
    input  redirect_valid, redirect_pc,
    input  branch_count, mispredict_count,
    input  overflow, underflow
  );

  modport slave (
    input  push, push_pc, push_taken, push_target,
    input  resolve_valid, resolve_taken, resolve_target,
    input  flush,
    output full, empty, count,
    output redirect_valid, redirect_pc,
    output branch_count, mispredict_count,
    output overflow, underflow
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches, checked at execute resolve.
// Mispredicts flush younger entries and emit a one-cycle redirect.
module branch_resolve_queue #(
  parameter int DEPTH = 4
) (
  input logic                  CLK,
  input logic                  nRST,
  branch_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t        state;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          redir_v;
  logic [31:0]   redir_pc;
  logic [31:0]   br_cnt;
  logic [31:0]   mis_cnt;
  logic          ovf;
  logic          unf;

  logic [31:0] pc_m  [DEPTH];
  logic        tk_m  [DEPTH];
  logic [31:0] tg_m  [DEPTH];

  logic        full;
  logic        empty;
  logic        run;
  logic        res_ok;
  logic        mispred;
  logic        mis;
  logic        pop;
  logic        push_ok;
  logic        ovf_set;
  logic        unf_set;
  logic [31:0] fix_pc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign bus.full             = full;
  assign bus.empty            = empty;
  assign bus.count            = count;
  assign bus.redirect_valid   = redir_v;
  assign bus.redirect_pc      = redir_pc;
  assign bus.branch_count     = br_cnt;
  assign bus.mispredict_count = mis_cnt;
  assign bus.overflow         = ovf;
  assign bus.underflow        = unf;

  // compare the head entry against the resolved outcome
  always_comb begin
    run     = 1'b0;
    res_ok  = 1'b0;
    mispred = 1'b0;
    mis     = 1'b0;
    pop     = 1'b0;
    push_ok = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    fix_pc  = pc_m[head] + 32'd4;
    run     = (state == RUN) && !bus.flush;
    res_ok  = run && bus.resolve_valid && !empty;
    unf_set = run && bus.resolve_valid && empty;
    mispred = (bus.resolve_taken != tk_m[head]) ||
              (bus.resolve_taken && tk_m[head] &&
               (bus.resolve_target != tg_m[head]));
    mis     = res_ok && mispred;
    pop     = res_ok && !mispred;
    if (bus.resolve_taken)
      fix_pc = bus.resolve_target;
    push_ok = run && bus.push && !mis && (!full || pop);
    ovf_set = run && bus.push && !mis && full && !pop;
  end

  // entry storage, written at tail; never reset
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      pc_m[tail] <= bus.push_pc;
      tk_m[tail] <= bus.push_taken;
      tg_m[tail] <= bus.push_target;
    end
  end

  // control FSM, pointers, counters and sticky flags
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= RUN;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      redir_v  <= 1'b0;
      redir_pc <= 32'h0;
      br_cnt   <= 32'h0;
      mis_cnt  <= 32'h0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (bus.flush) begin
      state   <= RUN;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      redir_v <= 1'b0;
    end else if (state == REDIRECT) begin
      state   <= RUN;
      redir_v <= 1'b0;
    end else begin
      if (res_ok && br_cnt != 32'hFFFF_FFFF)
        br_cnt <= br_cnt + 32'd1;
      if (unf_set)
        unf <= 1'b1;
      if (ovf_set)
        ovf <= 1'b1;
      if (mis) begin
        state    <= REDIRECT;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        redir_v  <= 1'b1;
        redir_pc <= fix_pc;
        if (mis_cnt != 32'hFFFF_FFFF)
          mis_cnt <= mis_cnt + 32'd1;
      end else begin
        if (pop)
          head <= head + PW'(1);
        if (push_ok)
          tail <= tail + PW'(1);
        unique case ({push_ok, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed + randomized bench for branch_resolve_queue.
// Reference model is a queue of predictions plus flags.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  branch_resolve_queue_if #(.DEPTH(DEPTH)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  ent_t        mq[$];
  logic        m_redir = 1'b0;
  logic [31:0] m_rpc = 32'h0;
  logic [31:0] m_bc = 32'h0;
  logic [31:0] m_mc = 32'h0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_redir));
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  // behavioural rules applied to one clock edge
  task automatic model(input logic p, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tg,
                       input logic rv, input logic rt,
                       input logic [31:0] rg, input logic fl,
                       input logic rn);
    ent_t e;
    ent_t h;
    logic mis;
    if (!rn) begin
      mq.delete();
      m_redir = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
      m_ovf = 0; m_unf = 0;
    end else if (fl) begin
      mq.delete();
      m_redir = 0;
    end else if (m_redir) begin
      m_redir = 0;
    end else begin
      mis = 0;
      m_redir = 0;
      if (rv) begin
        if (mq.size() == 0) m_unf = 1;
        else begin
          h = mq[0];
          if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
          if (rt != h.tk || (rt && rg != h.tg)) begin
            mis = 1;
            if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
            m_rpc = rt ? rg : h.pc + 32'd4;
            mq.delete();
            m_redir = 1;
          end else begin
            void'(mq.pop_front());
          end
        end
      end
      if (p && !mis) begin
        if (mq.size() < DEPTH) begin
          e.pc = pc; e.tk = tk; e.tg = tg;
          mq.push_back(e);
        end else m_ovf = 1;
      end
    end
  endtask

  task automatic cyc(input logic p, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tg,
                     input logic rv, input logic rt,
                     input logic [31:0] rg, input logic fl,
                     input logic rn = 1'b1);
    bus.push = p;
    bus.push_pc = pc;
    bus.push_taken = tk;
    bus.push_target = tg;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.resolve_target = rg;
    bus.flush = fl;
    nRST = rn;
    @(posedge CLK);
    model(p, pc, tk, tg, rv, rt, rg, fl, rn);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pushb(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg);
    cyc(1, pc, tk, tg, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rg);
    cyc(0, 0, 0, 0, 1, rt, rg, 0);
  endtask

  logic [31:0] sbc;
  logic [31:0] smc;

  initial begin
    logic p, tk, rv, rt, fl, rn;
    logic [31:0] pc, tg, rg;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_redir", 32'(bus.redirect_valid), 32'd0);

    pushb(32'h100, 1, 32'h0F0);
    resolve(1, 32'h0F0);
    chk("tp1_bc", bus.branch_count, 32'd1);
    chk("tp1_empty", 32'(bus.empty), 32'd1);
    idle();
    chk("tp1_noredir", 32'(bus.redirect_valid), 32'd0);

    pushb(32'h200, 0, 32'h0);
    resolve(1, 32'h240);
    chk("tp2_redir", 32'(bus.redirect_valid), 32'd1);
    chk("tp2_rpc", bus.redirect_pc, 32'h240);
    chk("tp2_mc", bus.mispredict_count, 32'd1);
    idle();
    chk("tp2_oneshot", 32'(bus.redirect_valid), 32'd0);

    pushb(32'h300, 1, 32'h2F0);
    resolve(0, 32'h0);
    chk("tp3_rpc", bus.redirect_pc, 32'h304);
    idle();

    pushb(32'h400, 1, 32'h3C0);
    pushb(32'h404, 0, 32'h0);
    pushb(32'h408, 1, 32'h500);
    cyc(1, 32'h40C, 1, 32'h600, 1, 1, 32'h3C8, 0);
    chk("tp4_rpc", bus.redirect_pc, 32'h3C8);
    chk("tp4_count", 32'(bus.count), 32'd0);
    cyc(1, 32'h700, 0, 0, 1, 0, 0, 0);
    chk("tp4_redir_ignores", 32'(bus.count), 32'd0);
    idle();

    for (int i = 0; i < DEPTH; i++)
      pushb(32'h800 + 32'(i * 4), 0, 32'h0);
    chk("tp5_full", 32'(bus.full), 32'd1);
    pushb(32'h810, 0, 32'h0);
    chk("tp5_ovf", 32'(bus.overflow), 32'd1);
    cyc(1, 32'h814, 1, 32'h900, 1, 0, 0, 0);
    chk("tp5_count4", 32'(bus.count), 32'd4);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    pushb(32'hA00, 0, 32'h0);
    pushb(32'hA04, 0, 32'h0);
    sbc = bus.branch_count;
    smc = bus.mispredict_count;
    cyc(1, 32'hA08, 0, 0, 1, 1, 32'hB00, 1);
    chk("tp6_count", 32'(bus.count), 32'd0);
    idle();
    chk("tp6_noredir", 32'(bus.redirect_valid), 32'd0);
    chk("tp6_bc", bus.branch_count, sbc);
    chk("tp6_mc", bus.mispredict_count, smc);
    resolve(1, 32'h0);
    chk("tp6_unf", 32'(bus.underflow), 32'd1);

    pushb(32'hC00, 1, 32'hC40);
    resolve(0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_in_redirect", 32'(bus.redirect_valid), 32'd0);

    for (int i = 0; i < 800; i++) begin
      p  = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      rn = !($urandom_range(0, 99) < 1);
      pc = {$urandom_range(0, 32'hFFFF), 2'b00};
      if (i % 97 == 0) pc = 32'hFFFF_FFFC;
      tk = 1'($urandom_range(0, 1));
      tg = {28'h0, 4'($urandom_range(0, 3)), 2'b00};
      rt = 1'($urandom_range(0, 1));
      rg = {28'h0, 4'($urandom_range(0, 3)), 2'b00};
      if (mq.size() > 0 && $urandom_range(0, 99) < 75) begin
        rt = mq[0].tk;
        if (rt) rg = mq[0].tg;
      end
      cyc(p, pc, tk, tg, rv, rt, rg, fl, rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
